// File: rtl/mul_pkg.sv
// Shared types and default constants for the shift-add multiply scheduler.
package mul_pkg;

   localparam int         DEF_WIDTH  = 32;
   localparam logic [5:0] DEF_ADD_OP = 6'd27;
   localparam logic [5:0] DEF_NOP_OP = 6'd0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      TEST  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/mul_sched_if.sv
// Requester/datapath bundle of the multiply scheduler.
// Optional abort/aborted pair is present only with MUL_SCHED_ABORT_EN defined.
interface mul_sched_if;

   logic [1:0] req;
   logic       lsb;
   logic [1:0] gnt;
   logic       sel;
   logic       wrctrl;
   logic       strctrl;
   logic       shctrl;
   logic [5:0] addctrl;
   logic       busy;
   logic       done;
   logic       done_id;
`ifdef MUL_SCHED_ABORT_EN
   logic       abort;
   logic       aborted;
`endif

   // master: the scheduler itself; slave: requesters and datapath
   modport master (
      input  req, lsb,
`ifdef MUL_SCHED_ABORT_EN
      input  abort,
      output aborted,
`endif
      output gnt, sel, wrctrl, strctrl, shctrl, addctrl, busy, done, done_id
   );

   modport slave (
      output req, lsb,
`ifdef MUL_SCHED_ABORT_EN
      output abort,
      input  aborted,
`endif
      input  gnt, sel, wrctrl, strctrl, shctrl, addctrl, busy, done, done_id
   );

endinterface

// File: rtl/mul_sched_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       valid
);

   always_comb begin
      valid  = |req;
      winner = (req == 2'b11) ? ~last : req[1];
   end

endmodule

// File: rtl/mul_sched.sv
// Shift-add multiply control FSM with two-requester round-robin ownership.
// Define MUL_SCHED_ABORT_EN to add the abort input and aborted pulse.
module mul_sched
   import mul_pkg::*;
#(
   parameter int         WIDTH  = DEF_WIDTH,
   parameter logic [5:0] ADD_OP = DEF_ADD_OP,
   parameter logic [5:0] NOP_OP = DEF_NOP_OP
) (
   input logic       clk,
   input logic       reset,
   mul_sched_if.master bus
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic             owner;
   logic             last;
   logic             arb_winner;
   logic             arb_valid;
   logic             abort_hit;

   rr_arb2 u_arb (
      .req    (bus.req),
      .last   (last),
      .winner (arb_winner),
      .valid  (arb_valid)
   );

`ifdef MUL_SCHED_ABORT_EN
   logic aborted_q;

   always_comb begin
      abort_hit = bus.abort && (state == LOAD || state == TEST || state == SHIFT);
   end

   always_ff @(posedge clk) begin
      if (reset) aborted_q <= 1'b0;
      else       aborted_q <= abort_hit;
   end

   assign bus.aborted = aborted_q;
`else
   assign abort_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Operation context: owner, last-served and iteration counter
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         owner <= 1'b0;
         last  <= 1'b1;
      end else begin
         case (state)
            IDLE:    if (arb_valid) owner <= arb_winner;
            LOAD:    cnt <= '0;
            SHIFT:   cnt <= cnt + 1'b1;
            DONE:    last <= owner;
            default: ;
         endcase
         if (abort_hit) last <= owner;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (arb_valid) state_nx = LOAD;
         LOAD:    state_nx = TEST;
         TEST:    state_nx = SHIFT;
         SHIFT:   state_nx = (cnt == CNT_W'(WIDTH - 1)) ? DONE : TEST;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (abort_hit) state_nx = IDLE;
   end

   // addctrl is the only output that also looks at an input (lsb)
   always_comb begin
      bus.gnt     = 2'b00;
      bus.sel     = owner;
      bus.wrctrl  = 1'b0;
      bus.strctrl = 1'b0;
      bus.shctrl  = 1'b0;
      bus.addctrl = NOP_OP;
      bus.busy    = (state != IDLE);
      bus.done    = 1'b0;
      bus.done_id = 1'b0;
      case (state)
         LOAD: begin
            bus.wrctrl = 1'b1;
            bus.gnt    = owner ? 2'b10 : 2'b01;
         end
         TEST: begin
            bus.strctrl = 1'b1;
            bus.addctrl = bus.lsb ? ADD_OP : NOP_OP;
         end
         SHIFT: bus.shctrl = 1'b1;
         DONE: begin
            bus.done    = 1'b1;
            bus.done_id = owner;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: directed scenarios on a WIDTH=32 instance and a
// randomized run of a WIDTH=4 instance against a timeline reference model.
module tb_mul_sched;

   localparam int W4 = 4;

   logic clk;
   logic rst32, rst4;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;

   mul_sched_if bus32 ();
   mul_sched_if bus4 ();

   mul_sched #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst32), .bus(bus32.master));
   mul_sched #(.WIDTH(W4)) dut4  (.clk(clk), .reset(rst4),  .bus(bus4.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
      cyc++;
   endtask

   // Reference model state for the WIDTH=4 instance
   bit m_busy, m_owner, m_last, m_abp;
   int m_k;

   initial begin
      int  gcyc, dcyc, nstr, nsh, g1, g2, d1, d2, nd, nctl;
      bit  hit, r_rst, r_abort;
      logic [1:0] r_req;
      logic e_str, e_sh, e_wr, e_done, e_id;
      logic [1:0] e_gnt;
      logic [5:0] e_add;

      rst32 = 1'b1; rst4 = 1'b1;
      bus32.req = 2'b00; bus32.lsb = 1'b0;
      bus4.req  = 2'b00; bus4.lsb  = 1'b0;
`ifdef MUL_SCHED_ABORT_EN
      bus32.abort = 1'b0; bus4.abort = 1'b0;
`endif
      tick(); tick();
      check("rst busy",    bus32.busy, 0);
      check("rst gnt",     bus32.gnt, 0);
      check("rst ctl",     {bus32.wrctrl, bus32.strctrl, bus32.shctrl}, 0);
      check("rst done",    {bus32.done, bus32.done_id, bus32.sel}, 0);
      check("rst addctrl", bus32.addctrl, 0);
`ifdef MUL_SCHED_ABORT_EN
      check("rst aborted", bus32.aborted, 0);
`endif

      // Single requester, lsb alternating on successive TEST cycles
      rst32 = 1'b0; bus32.req = 2'b01; bus32.lsb = 1'b1;
      gcyc = -1000; dcyc = -1; nstr = 0; nsh = 0;
      for (int i = 0; i < 200 && dcyc < 0; i++) begin
         tick();
         nctl = int'(bus32.wrctrl) + int'(bus32.strctrl) + int'(bus32.shctrl);
         check("A excl", nctl <= 1, 1);
         if (bus32.gnt != 2'b00) begin
            check("A gnt", bus32.gnt, 2'b01);
            check("A wrctrl", bus32.wrctrl, 1);
            gcyc = cyc;
            bus32.req = 2'b00;
         end
         if (bus32.busy) check("A sel", bus32.sel, 0);
         if (bus32.strctrl) begin
            check("A addctrl test", bus32.addctrl, bus32.lsb ? 27 : 0);
            nstr++;
            bus32.lsb = ~bus32.lsb;
         end else begin
            check("A addctrl idle", bus32.addctrl, 0);
         end
         if (bus32.shctrl) nsh++;
         if (bus32.done) begin
            dcyc = cyc;
            check("A done_id", bus32.done_id, 0);
         end
      end
      check("A latency", dcyc - gcyc, 65);
      check("A strctrl count", nstr, 32);
      check("A shctrl count", nsh, 32);

      // Tie: requester 0 first, then requester 1 two cycles after done
      rst32 = 1'b1; tick(); rst32 = 1'b0;
      bus32.req = 2'b11;
      g1 = -1; g2 = -1000; d1 = -1; d2 = -1;
      for (int i = 0; i < 400 && d2 < 0; i++) begin
         tick();
         if (bus32.gnt != 2'b00) begin
            if (g1 < 0) begin
               check("B gnt1", bus32.gnt, 2'b01);
               g1 = cyc; bus32.req[0] = 1'b0;
            end else begin
               check("B gnt2", bus32.gnt, 2'b10);
               g2 = cyc; bus32.req[1] = 1'b0;
            end
         end
         if (bus32.done) begin
            if (d1 < 0) begin
               d1 = cyc; check("B done_id1", bus32.done_id, 0);
            end else begin
               d2 = cyc; check("B done_id2", bus32.done_id, 1);
            end
         end
      end
      check("B gap", g2 - d1, 2);
      check("B second done", d2 >= 0, 1);

      // Reset in the SHIFT of iteration 10
      rst32 = 1'b1; tick(); rst32 = 1'b0;
      bus32.req = 2'b01; nsh = 0; hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         tick();
         if (bus32.gnt != 2'b00) bus32.req = 2'b00;
         if (bus32.shctrl) begin
            nsh++;
            if (nsh == 10) begin rst32 = 1'b1; hit = 1'b1; end
         end
      end
      check("C reached", hit, 1);
      tick();
      check("C busy", bus32.busy, 0);
      check("C ctl", {bus32.gnt, bus32.wrctrl, bus32.strctrl, bus32.shctrl, bus32.done}, 0);
      check("C addctrl", bus32.addctrl, 0);
      rst32 = 1'b0; nd = 0;
      repeat (100) begin
         tick();
         if (bus32.done) nd++;
      end
      check("C no done", nd, 0);

      // Randomized run of the WIDTH=4 instance against the timeline model
      m_busy = 0; m_owner = 0; m_last = 1; m_abp = 0; m_k = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         r_rst   = (i < 2) || ($urandom_range(0, 79) == 0);
         r_req   = 2'($urandom);
         r_abort = ($urandom_range(0, 15) == 0);
         rst4 = r_rst;
         bus4.req = r_req;
         bus4.lsb = 1'($urandom);
`ifdef MUL_SCHED_ABORT_EN
         bus4.abort = r_abort;
`else
         r_abort = 1'b0;
`endif
         #1;
         e_gnt = 2'b00; e_wr = 0; e_str = 0; e_sh = 0; e_add = 6'd0; e_done = 0; e_id = 0;
         if (m_busy) begin
            if (m_k == 0) begin
               e_gnt = m_owner ? 2'b10 : 2'b01; e_wr = 1;
            end else if (m_k <= 2 * W4) begin
               if (m_k % 2 == 1) begin
                  e_str = 1; e_add = bus4.lsb ? 6'd27 : 6'd0;
               end else begin
                  e_sh = 1;
               end
            end else begin
               e_done = 1; e_id = m_owner;
            end
         end
         check("R gnt",     bus4.gnt, e_gnt);
         check("R wrctrl",  bus4.wrctrl, e_wr);
         check("R strctrl", bus4.strctrl, e_str);
         check("R shctrl",  bus4.shctrl, e_sh);
         check("R addctrl", bus4.addctrl, e_add);
         check("R busy",    bus4.busy, m_busy);
         check("R done",    bus4.done, e_done);
         check("R done_id", bus4.done_id, e_id);
         check("R sel",     bus4.sel, m_owner);
`ifdef MUL_SCHED_ABORT_EN
         check("R aborted", bus4.aborted, m_abp);
`endif
         if (r_rst) begin
            m_busy = 0; m_owner = 0; m_last = 1; m_abp = 0;
         end else begin
            m_abp = 0;
            if (!m_busy) begin
               if (r_req != 2'b00) begin
                  m_owner = (r_req == 2'b11) ? ~m_last : r_req[1];
                  m_busy = 1; m_k = 0;
               end
            end else if (r_abort && m_k <= 2 * W4) begin
               m_abp = 1; m_last = m_owner; m_busy = 0;
            end else if (m_k == 2 * W4 + 1) begin
               m_last = m_owner; m_busy = 0;
            end else begin
               m_k++;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
